// File: rtl/pipeline_ctrl.sv
// Stall / flush / forward sequencer for the 3-stage RV32 pipeline (F -> DX -> MW).
// Stall and bubble outputs are combinational from state and inputs; forward selects,
// the timeout flag and the stall counter are registered.
module pipeline_ctrl #(
    parameter int unsigned TIMEOUT = 256,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hazard_dx_ra,
    input  logic             hazard_dx_rb,
    input  logic             hazard_mw_ra,
    input  logic             hazard_mw_rb,
    input  logic             dx_is_load,
    input  logic             dx_redirect,
    input  logic             imem_busy,
    input  logic             dmem_busy,
    output logic             f_stall,
    output logic             dx_stall,
    output logic             mw_stall,
    output logic             dx_bubble,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int unsigned WAIT_W = $clog2(TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_MEM_WAIT = 2'd1;
    localparam logic [1:0] ST_FLUSH    = 2'd2;

    localparam logic [1:0] SEL_RF = 2'd0;
    localparam logic [1:0] SEL_MW = 2'd1;
    localparam logic [1:0] SEL_WB = 2'd2;

    logic [1:0]        state_q;
    logic [1:0]        state_d;
    logic              redirect_pend_q;
    logic              redirect_pend_d;
    logic [WAIT_W-1:0] wait_cnt_q;
    logic [WAIT_W-1:0] wait_cnt_d;
    logic              mem_timeout_d;
    logic [1:0]        fwd_a_d;
    logic [1:0]        fwd_b_d;
    logic [CNT_W-1:0]  stall_cnt_d;
    logic              load_use_c;
    logic [1:0]        sel_a_c;
    logic [1:0]        sel_b_c;

    // Hazard decode: load-use detection and per-operand forward source (DX beats MW)
    assign load_use_c = dx_is_load & (hazard_dx_ra | hazard_dx_rb);
    assign sel_a_c    = hazard_dx_ra ? SEL_MW : (hazard_mw_ra ? SEL_WB : SEL_RF);
    assign sel_b_c    = hazard_dx_rb ? SEL_MW : (hazard_mw_rb ? SEL_WB : SEL_RF);

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_RUN;
            redirect_pend_q <= 1'b0;
            wait_cnt_q      <= '0;
            mem_timeout     <= 1'b0;
            fwd_a_sel       <= SEL_RF;
            fwd_b_sel       <= SEL_RF;
            stall_cnt       <= '0;
        end else begin
            state_q         <= state_d;
            redirect_pend_q <= redirect_pend_d;
            wait_cnt_q      <= wait_cnt_d;
            mem_timeout     <= mem_timeout_d;
            fwd_a_sel       <= fwd_a_d;
            fwd_b_sel       <= fwd_b_d;
            stall_cnt       <= stall_cnt_d;
        end
    end

    // Next state, stall/bubble generation and registered-output next values
    always_comb begin
        state_d         = state_q;
        redirect_pend_d = redirect_pend_q;
        wait_cnt_d      = wait_cnt_q;
        mem_timeout_d   = mem_timeout;
        fwd_a_d         = fwd_a_sel;
        fwd_b_d         = fwd_b_sel;
        stall_cnt_d     = stall_cnt;
        f_stall         = 1'b0;
        dx_stall        = 1'b0;
        mw_stall        = 1'b0;
        dx_bubble       = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (dmem_busy) begin
                    f_stall         = 1'b1;
                    dx_stall        = 1'b1;
                    mw_stall        = 1'b1;
                    state_d         = ST_MEM_WAIT;
                    redirect_pend_d = dx_redirect;
                    wait_cnt_d      = '0;
                end else if (dx_redirect) begin
                    dx_bubble = 1'b1;
                end else if (load_use_c || imem_busy) begin
                    f_stall   = 1'b1;
                    dx_bubble = 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                if (dmem_busy) begin
                    f_stall  = 1'b1;
                    dx_stall = 1'b1;
                    mw_stall = 1'b1;
                    if (wait_cnt_q == WAIT_LAST) begin
                        mem_timeout_d = 1'b1;
                    end else begin
                        wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                    end
                end else begin
                    wait_cnt_d = '0;
                    state_d    = redirect_pend_q ? ST_FLUSH : ST_RUN;
                end
            end
            ST_FLUSH: begin
                // The wrong-path DX instruction is replaced by a NOP even if memory
                // stalls, so DX is reloaded rather than held.
                dx_bubble       = 1'b1;
                redirect_pend_d = 1'b0;
                state_d         = ST_RUN;
                if (dmem_busy) begin
                    f_stall         = 1'b1;
                    mw_stall        = 1'b1;
                    state_d         = ST_MEM_WAIT;
                    redirect_pend_d = dx_redirect;
                    wait_cnt_d      = '0;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        if (!dx_stall) begin
            fwd_a_d = dx_bubble ? SEL_RF : sel_a_c;
            fwd_b_d = dx_bubble ? SEL_RF : sel_b_c;
        end

        if (f_stall && (stall_cnt != '1)) begin
            stall_cnt_d = stall_cnt + CNT_W'(1);
        end

        // Combinational outputs read as idle while reset is asserted
        if (!rst_n) begin
            f_stall   = 1'b0;
            dx_stall  = 1'b0;
            mw_stall  = 1'b0;
            dx_bubble = 1'b0;
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Randomized bench for pipeline_ctrl against a cycle-level behavioural model.
module tb_pipeline_ctrl;

    localparam int unsigned TIMEOUT = 8;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned CNT_MAX = 15;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             hazard_dx_ra, hazard_dx_rb, hazard_mw_ra, hazard_mw_rb;
    logic             dx_is_load, dx_redirect, imem_busy, dmem_busy;
    logic             f_stall, dx_stall, mw_stall, dx_bubble;
    logic [1:0]       fwd_a_sel, fwd_b_sel;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_cnt;

    always #5 clk = ~clk;

    pipeline_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .hazard_dx_ra (hazard_dx_ra),
        .hazard_dx_rb (hazard_dx_rb),
        .hazard_mw_ra (hazard_mw_ra),
        .hazard_mw_rb (hazard_mw_rb),
        .dx_is_load   (dx_is_load),
        .dx_redirect  (dx_redirect),
        .imem_busy    (imem_busy),
        .dmem_busy    (dmem_busy),
        .f_stall      (f_stall),
        .dx_stall     (dx_stall),
        .mw_stall     (mw_stall),
        .dx_bubble    (dx_bubble),
        .fwd_a_sel    (fwd_a_sel),
        .fwd_b_sel    (fwd_b_sel),
        .mem_timeout  (mem_timeout),
        .stall_cnt    (stall_cnt)
    );

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;
    logic [3:0]  obs_comb;   // {f_stall, dx_stall, mw_stall, dx_bubble} seen in the last step

    // Model state: memory-wait episode, pending flush, counters
    bit          m_wait, m_flush_next, m_pend, m_to;
    int unsigned m_wcyc, m_scnt, m_fa, m_fb;

    task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    // Input vector: [7]dx_ra [6]dx_rb [5]mw_ra [4]mw_rb [3]load [2]redirect [1]imem [0]dmem
    task automatic apply(input logic [7:0] v);
        hazard_dx_ra = v[7];
        hazard_dx_rb = v[6];
        hazard_mw_ra = v[5];
        hazard_mw_rb = v[4];
        dx_is_load   = v[3];
        dx_redirect  = v[2];
        imem_busy    = v[1];
        dmem_busy    = v[0];
    endtask

    task automatic model_reset();
        m_wait = 0; m_flush_next = 0; m_pend = 0; m_to = 0;
        m_wcyc = 0; m_scnt = 0; m_fa = 0; m_fb = 0;
    endtask

    // Expected {f, dx, mw, bubble} for this cycle
    function automatic logic [3:0] exp_comb(input logic [7:0] v);
        logic f, d, m, b;
        f = 0; d = 0; m = 0; b = 0;
        if (m_wait) begin
            if (v[0]) begin f = 1; d = 1; m = 1; end
        end else if (m_flush_next) begin
            b = 1;
            if (v[0]) begin f = 1; m = 1; end
        end else if (v[0]) begin
            f = 1; d = 1; m = 1;
        end else if (v[2]) begin
            b = 1;
        end else if ((v[3] && (v[7] || v[6])) || v[1]) begin
            f = 1; b = 1;
        end
        return {f, d, m, b};
    endfunction

    task automatic model_advance(input logic [7:0] v, input logic [3:0] c);
        if (!c[2]) begin
            m_fa = c[0] ? 0 : (v[7] ? 1 : (v[5] ? 2 : 0));
            m_fb = c[0] ? 0 : (v[6] ? 1 : (v[4] ? 2 : 0));
        end
        if (c[3] && m_scnt < CNT_MAX) m_scnt++;
        if (m_wait) begin
            if (v[0]) begin
                m_wcyc++;
                if (m_wcyc >= TIMEOUT) m_to = 1;
            end else begin
                m_wait       = 0;
                m_flush_next = m_pend;
                m_pend       = 0;
            end
        end else if (v[0]) begin
            m_wait       = 1;
            m_pend       = v[2];
            m_wcyc       = 0;
            m_flush_next = 0;
        end else begin
            m_flush_next = 0;
        end
    endtask

    // One clock cycle: drive at negedge, check comb outputs, check registers after posedge
    task automatic step(input logic [7:0] v);
        logic [3:0] e;
        @(negedge clk);
        apply(v);
        #1;
        e = exp_comb(v);
        obs_comb = {f_stall, dx_stall, mw_stall, dx_bubble};
        chk("stalls", 32'(obs_comb), 32'(e));
        model_advance(v, e);
        @(posedge clk);
        #1;
        chk("fwd_a", 32'(fwd_a_sel), m_fa);
        chk("fwd_b", 32'(fwd_b_sel), m_fb);
        chk("timeout", 32'(mem_timeout), 32'(m_to));
        chk("stall_cnt", 32'(stall_cnt), m_scnt);
    endtask

    // Async reset with random inputs held; everything must read zero
    task automatic do_reset();
        @(negedge clk);
        apply(8'($urandom));
        rst_n = 1'b0;
        #1;
        chk("rst_stalls", 32'({f_stall, dx_stall, mw_stall, dx_bubble}), 0);
        chk("rst_regs", 32'({fwd_a_sel, fwd_b_sel, mem_timeout, stall_cnt}), 0);
        repeat (2) @(posedge clk);
        #1;
        apply(8'($urandom));
        #1;
        chk("rst_hold", 32'({f_stall, dx_stall, mw_stall, dx_bubble, fwd_a_sel,
                             fwd_b_sel, mem_timeout, stall_cnt}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        apply(8'h00);
        model_reset();
    endtask

    initial begin
        int unsigned burst;
        logic [7:0]  v;
        rst_n = 1'b0;
        apply(8'h00);
        model_reset();

        // Reset, then first advance
        do_reset();
        step(8'b0000_0000);

        // Load-use: one bubble cycle, then MW forward
        step(8'b1000_1000);
        chk("lu_bubble", 32'(obs_comb), 32'(4'b1001));
        chk("lu_cnt", 32'(stall_cnt), 1);
        step(8'b0010_0000);
        chk("lu_fwd_a", 32'(fwd_a_sel), 2);

        // ALU forward, DX beats MW
        step(8'b0101_0000);
        chk("alu_fwd_b", 32'(fwd_b_sel), 1);
        chk("alu_nostall", 32'(obs_comb), 0);
        step(8'b0010_0000);
        chk("mw_fwd_a", 32'(fwd_a_sel), 2);

        // Memory wait with pending redirect -> flush bubble
        do_reset();
        step(8'b0000_0101);
        repeat (4) step(8'b0000_0001);
        chk("mw_stall5", 32'(obs_comb), 32'(4'b1110));
        step(8'b0000_0000);
        chk("mw_release", 32'(obs_comb), 0);
        step(8'b0000_0000);
        chk("flush_bub", 32'(obs_comb), 32'(4'b0001));
        step(8'b0000_0000);
        chk("back_run", 32'(obs_comb), 0);

        // Memory busy during the flush cycle
        step(8'b0000_0101);
        step(8'b0000_0001);
        step(8'b0000_0000);
        step(8'b0000_0001);
        chk("flush_busy", 32'(obs_comb), 32'(4'b1011));
        step(8'b0000_0000);
        step(8'b0000_0000);

        // Timeout: sticky after 8th MEM_WAIT cycle
        do_reset();
        for (int i = 1; i <= 10; i++) begin
            step(8'b0000_0001);
            if (i == 8) chk("to_early", 32'(mem_timeout), 0);
            if (i == 9) chk("to_set", 32'(mem_timeout), 1);
        end
        step(8'b0000_0000);
        chk("to_sticky", 32'(mem_timeout), 1);
        step(8'b0000_0000);

        // Reset mid memory wait
        step(8'b0000_0101);
        step(8'b0000_0001);
        do_reset();
        step(8'b0000_0000);
        chk("rst_mid_run", 32'(obs_comb), 0);

        // Redirect beats load-use
        step(8'b1000_1100);
        chk("redir_prio", 32'(obs_comb), 32'(4'b0001));

        // Counter saturation
        do_reset();
        repeat (20) step(8'b0000_0010);
        chk("cnt_sat", 32'(stall_cnt), CNT_MAX);

        // Randomized traffic
        do_reset();
        burst = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
                burst = 0;
            end
            v = 8'($urandom);
            if (burst == 0 && $urandom_range(0, 19) == 0) burst = $urandom_range(1, 12);
            v[0] = (burst != 0);
            if (burst != 0) burst--;
            if ($urandom_range(0, 3) != 0) v[2] = 1'b0;
            if ($urandom_range(0, 2) != 0) v[1] = 1'b0;
            step(v);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
